// File: rtl/ifetch.sv
// ifetch: instruction-fetch front end with a 2-entry instruction queue and redirect flush.
// Optional IF_MISALIGN_CHECK_EN adds if_o_misalign and a halt on misaligned redirect targets.
module ifetch #(
   parameter int                  PC_WIDTH = 32,
   parameter int                  IWIDTH   = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                if_clk,
   input  logic                if_rst,
   output logic                if_o_ce,
   output logic [PC_WIDTH-1:0] if_o_address,
   input  logic [IWIDTH-1:0]   if_i_instr,
   input  logic                if_i_ce,
   input  logic                if_i_stall,
   input  logic                if_i_redirect,
   input  logic [PC_WIDTH-1:0] if_i_target,
`ifdef IF_MISALIGN_CHECK_EN
   output logic                if_o_misalign,
`endif
   output logic                if_o_valid,
   output logic [IWIDTH-1:0]   if_o_instr,
   output logic [PC_WIDTH-1:0] if_o_pc
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_HALT} state_t;
   state_t              r_state;
   logic [PC_WIDTH-1:0] r_pc, r_req_pc;
   logic                r_inflight, r_drop;
   logic [1:0]          r_count;
   logic [IWIDTH-1:0]   r_q_instr [2];
   logic [PC_WIDTH-1:0] r_q_pc [2];
   logic                w_pop, w_push, w_resp, w_issue, w_redir, w_bad, w_slot;
   logic [2:0]          w_occ;
`ifdef IF_MISALIGN_CHECK_EN
   logic                r_misalign;
   assign w_redir       = if_i_redirect && r_state != S_HALT;
   assign w_bad         = w_redir && |if_i_target[1:0];
   assign if_o_misalign = r_misalign;
`else
   assign w_redir = if_i_redirect;
   assign w_bad   = 1'b0;
`endif
   assign if_o_valid   = r_count != 2'd0;
   assign if_o_instr   = r_q_instr[0];
   assign if_o_pc      = r_q_pc[0];
   assign if_o_address = r_pc;
   assign w_pop        = if_o_valid && !if_i_stall;
   assign w_resp       = if_i_ce && r_inflight;
   assign w_push       = w_resp && !r_drop && !w_redir;
   // occupancy counts the in-flight request so the queue can never overflow
   assign w_occ        = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
   assign w_issue      = (r_state == S_RUN || r_state == S_FLUSH) && !w_redir && w_occ < 3'd2;
   assign if_o_ce      = w_issue;
   assign w_slot       = (r_count - {1'b0, w_pop}) != 2'd0;
   always_ff @(posedge if_clk or negedge if_rst) begin
      if (!if_rst) begin
         r_state      <= S_IDLE;
         r_pc         <= RESET_PC;
         r_req_pc     <= '0;
         r_inflight   <= 1'b0;
         r_drop       <= 1'b0;
         r_count      <= 2'd0;
         r_q_instr[0] <= '0;
         r_q_instr[1] <= '0;
         r_q_pc[0]    <= '0;
         r_q_pc[1]    <= '0;
`ifdef IF_MISALIGN_CHECK_EN
         r_misalign   <= 1'b0;
`endif
      end else if (w_bad) begin
         r_state    <= S_HALT;
         r_count    <= 2'd0;
         r_inflight <= 1'b0;
         r_drop     <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
         r_misalign <= 1'b1;
`endif
      end else if (w_redir) begin
         // a response landing this cycle is simply not pushed; only a still-pending one needs drop
         r_state    <= S_FLUSH;
         r_pc       <= if_i_target;
         r_count    <= 2'd0;
         r_inflight <= r_inflight & ~if_i_ce;
         r_drop     <= r_inflight & ~if_i_ce;
      end else begin
         if (r_state == S_IDLE || r_state == S_FLUSH) r_state <= S_RUN;
         if (w_issue) begin
            r_pc       <= r_pc + PC_WIDTH'(4);
            r_req_pc   <= r_pc;
            r_inflight <= 1'b1;
         end else if (w_resp) r_inflight <= 1'b0;
         if (w_resp && r_drop) r_drop <= 1'b0;
         if (w_pop) begin
            r_q_instr[0] <= r_q_instr[1];
            r_q_pc[0]    <= r_q_pc[1];
         end
         if (w_push) begin
            r_q_instr[w_slot] <= if_i_instr;
            r_q_pc[w_slot]    <= r_req_pc;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed vector table, reset/misalign sequences and a randomized run against a queue model.
module tb_ifetch;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        stall = 1'b0, redir = 1'b0, spur = 1'b0;
   logic [31:0] target = '0;
   logic        o_ce, o_valid;
   logic [31:0] o_addr, o_instr, o_pc;
   logic        im_ce = 1'b0;
   logic [31:0] im_instr = '0;
   logic        i_ce;
   logic [31:0] i_instr;
   int          cyc = 0;
   int          checks = 0, errors = 0;
`ifdef IF_MISALIGN_CHECK_EN
   logic        o_mis;
`endif

   ifetch #(.PC_WIDTH(32), .IWIDTH(32), .RESET_PC(32'h0)) dut (
      .if_clk(clk), .if_rst(rst_n),
      .if_o_ce(o_ce), .if_o_address(o_addr),
      .if_i_instr(i_instr), .if_i_ce(i_ce),
      .if_i_stall(stall), .if_i_redirect(redir), .if_i_target(target),
`ifdef IF_MISALIGN_CHECK_EN
      .if_o_misalign(o_mis),
`endif
      .if_o_valid(o_valid), .if_o_instr(o_instr), .if_o_pc(o_pc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
   endfunction

   // imem: one-cycle read latency; spur injects responses nobody asked for
   always @(posedge clk) begin
      im_ce    <= o_ce;
      im_instr <= mem(o_addr);
   end
   assign i_ce    = im_ce | spur;
   assign i_instr = im_ce ? im_instr : 32'hDEAD_BEEF;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h want %h", name, cyc, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset;
      rst_n = 1'b0; stall = 1'b0; redir = 1'b0; spur = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic        stall, redir;
      logic [31:0] target;
      logic        ce;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] pc;
   } vec_t;

   function automatic vec_t v(input logic s, input logic r, input logic [31:0] t, input logic c,
                              input logic [31:0] a, input logic va, input logic [31:0] p);
      vec_t x;
      x.stall = s; x.redir = r; x.target = t; x.ce = c; x.addr = a; x.valid = va; x.pc = p;
      return x;
   endfunction

   typedef struct {
      logic [31:0] pc;
      int          c;
   } ent_t;

   vec_t tbl[19];
   ent_t q[$];

   initial begin
      logic [31:0] fetch;
      int          rel;
      bit          running, exp_valid, pop, exp_ce;
      tbl[0]  = v(0, 0, 0,        0, 32'h0,   0, 0);
      tbl[1]  = v(0, 0, 0,        1, 32'h0,   0, 0);
      tbl[2]  = v(0, 0, 0,        1, 32'h4,   0, 0);
      tbl[3]  = v(0, 0, 0,        1, 32'h8,   1, 32'h0);
      tbl[4]  = v(1, 0, 0,        0, 32'hc,   1, 32'h4);
      tbl[5]  = v(1, 0, 0,        0, 32'hc,   1, 32'h4);
      tbl[6]  = v(1, 0, 0,        0, 32'hc,   1, 32'h4);
      tbl[7]  = v(0, 0, 0,        1, 32'hc,   1, 32'h4);
      tbl[8]  = v(0, 0, 0,        1, 32'h10,  1, 32'h8);
      tbl[9]  = v(0, 1, 32'h40,   0, 32'h14,  1, 32'hc);
      tbl[10] = v(0, 0, 0,        1, 32'h40,  0, 0);
      tbl[11] = v(0, 0, 0,        1, 32'h44,  0, 0);
      tbl[12] = v(0, 0, 0,        1, 32'h48,  1, 32'h40);
      tbl[13] = v(0, 0, 0,        1, 32'h4c,  1, 32'h44);
      tbl[14] = v(1, 0, 0,        0, 32'h50,  1, 32'h48);
      tbl[15] = v(1, 1, 32'h100,  0, 32'h50,  1, 32'h48);
      tbl[16] = v(1, 0, 0,        1, 32'h100, 0, 0);
      tbl[17] = v(0, 0, 0,        1, 32'h104, 0, 0);
      tbl[18] = v(0, 0, 0,        1, 32'h108, 1, 32'h100);

      @(negedge clk);
      #1;
      chk("rst_ce", 32'(o_ce), 0);
      chk("rst_valid", 32'(o_valid), 0);
      chk("rst_addr", o_addr, 0);
      chk("rst_instr", o_instr, 0);
      chk("rst_pc", o_pc, 0);
`ifdef IF_MISALIGN_CHECK_EN
      chk("rst_misalign", 32'(o_mis), 0);
`endif
      do_reset();

      for (int i = 0; i < 19; i++) begin
         stall = tbl[i].stall; redir = tbl[i].redir; target = tbl[i].target;
         #1;
         chk($sformatf("tbl%0d_ce", i), 32'(o_ce), 32'(tbl[i].ce));
         chk($sformatf("tbl%0d_addr", i), o_addr, tbl[i].addr);
         chk($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tbl[i].valid));
         if (tbl[i].valid) begin
            chk($sformatf("tbl%0d_pc", i), o_pc, tbl[i].pc);
            chk($sformatf("tbl%0d_instr", i), o_instr, mem(tbl[i].pc));
         end
         step();
      end
      stall = 1'b0; redir = 1'b0;

      // async reset mid-stream, then a spurious response right after release
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ce", 32'(o_ce), 0);
      chk("arst_valid", 32'(o_valid), 0);
      chk("arst_addr", o_addr, 0);
      chk("arst_instr", o_instr, 0);
      chk("arst_pc", o_pc, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1; spur = 1'b1;
      #1;
      chk("rel0_ce", 32'(o_ce), 0);
      chk("rel0_valid", 32'(o_valid), 0);
      step();
      #1;
      chk("rel1_ce", 32'(o_ce), 1);
      chk("rel1_addr", o_addr, 0);
      chk("rel1_valid", 32'(o_valid), 0);
      step();
      spur = 1'b0;
      #1;
      chk("rel2_addr", o_addr, 4);
      chk("rel2_valid", 32'(o_valid), 0);
      step();
      #1;
      chk("rel3_valid", 32'(o_valid), 1);
      chk("rel3_pc", o_pc, 0);
      chk("rel3_instr", o_instr, mem(0));

`ifdef IF_MISALIGN_CHECK_EN
      step();
      redir = 1'b1; target = 32'h42;
      #1;
      chk("mis_redir_ce", 32'(o_ce), 0);
      step();
      redir = 1'b0;
      #1;
      chk("mis_flag", 32'(o_mis), 1);
      chk("mis_ce", 32'(o_ce), 0);
      chk("mis_valid", 32'(o_valid), 0);
      step();
      redir = 1'b1; target = 32'h80;
      #1;
      chk("halt_redir_ce", 32'(o_ce), 0);
      step();
      redir = 1'b0;
      repeat (3) begin
         #1;
         chk("halt_ce", 32'(o_ce), 0);
         chk("halt_valid", 32'(o_valid), 0);
         chk("halt_flag", 32'(o_mis), 1);
         step();
      end
      do_reset();
      #1;
      chk("mis_cleared", 32'(o_mis), 0);
      @(negedge clk);
`else
      step();
`endif

      // randomized run against an issue/deliver queue model
      do_reset();
      rel = cyc; fetch = 32'h0; q.delete();
      for (int n = 0; n < 3000; n++) begin
         running = (cyc - rel) >= 1;
         stall = $urandom_range(0, 99) < ((((cyc / 64) % 2) == 0) ? 15 : 70);
         redir = running && ($urandom_range(0, 99) < 6);
         target = $urandom;
`ifdef IF_MISALIGN_CHECK_EN
         target[1:0] = 2'b00;
`else
         if ($urandom_range(0, 3) != 0) target[1:0] = 2'b00;
`endif
         spur = $urandom_range(0, 9) == 0;
         #1;
         exp_valid = q.size() > 0 && (q[0].c + 2 <= cyc);
         chk("rnd_valid", 32'(o_valid), 32'(exp_valid));
         if (exp_valid) begin
            chk("rnd_pc", o_pc, q[0].pc);
            chk("rnd_instr", o_instr, mem(q[0].pc));
         end
         chk("rnd_addr", o_addr, fetch);
         pop = exp_valid && !stall;
         if (redir) begin
            chk("rnd_redir_ce", 32'(o_ce), 0);
            q.delete();
            fetch = target;
         end else begin
            exp_ce = running && (q.size() - int'(pop) < 2);
            chk("rnd_ce", 32'(o_ce), 32'(exp_ce));
            if (pop) void'(q.pop_front());
            if (exp_ce) begin
               q.push_back('{pc: fetch, c: cyc});
               fetch = fetch + 32'd4;
            end
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
